// File: rtl/mem_arb_pkg.sv
// Shared encodings and default widths for the unified-memory arbiter and the datapath memory mux.
package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_DATA_W = 16;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// CPU, DMA and memory-macro signals of the arbiter; master = requesters and memory, slave = arbiter.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );

endinterface

// File: rtl/mem_arb_rd_tracker.sv
// Read-latency tracker: counts MEM_LAT cycles per issued read and steers mem_rdata to the owning port.
// arb_open is high in IDLE and on the final latency cycle, so a new access may overlap the read return.
module mem_arb_rd_tracker
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              rd_issue,
  input  owner_t            rd_owner,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              arb_open,
  output logic              busy,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata
);

  arb_state_t state_q, state_d;
  logic [2:0] lat_q, lat_d;
  owner_t     own_q, own_d;
  logic       rd_last;

  assign rd_last = (state_q == RD_WAIT) && (lat_q == 3'd1);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      lat_q   <= 3'd0;
      own_q   <= OWN_CPU;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      own_q   <= own_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    own_d   = own_q;
    case (state_q)
      IDLE: begin
        if (rd_issue) begin
          state_d = RD_WAIT;
          lat_d   = 3'(MEM_LAT);
          own_d   = rd_owner;
        end
      end
      RD_WAIT: begin
        lat_d = lat_q - 3'd1;
        if (rd_last) begin
          // Final cycle doubles as an arbitration slot: reload on a new read
          if (rd_issue) begin
            lat_d = 3'(MEM_LAT);
            own_d = rd_owner;
          end else begin
            state_d = IDLE;
            lat_d   = 3'd0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        lat_d   = 3'd0;
      end
    endcase
  end

  assign arb_open   = (state_q == IDLE) || rd_last;
  assign busy       = (state_q == RD_WAIT);
  assign cpu_rvalid = rd_last && (own_q == OWN_CPU);
  assign dma_rvalid = rd_last && (own_q == OWN_DMA);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign dma_rdata  = dma_rvalid ? mem_rdata : '0;

endmodule

// File: rtl/mem_port_arbiter.sv
// CPU-priority arbiter for the single-port unified memory; grant and access issue in the same cycle, reads return MEM_LAT later.
// Losing/blocked requester holds req until its gnt; `MEM_ARB_STARVE_EN forces a DMA win after STARVE_LIM wait cycles.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_LIM = 8
) (
  input logic               CLK,
  input logic               Reset,
  mem_port_arbiter_if.slave bus
);

  logic              arb_open;
  logic              grant_ok;
  logic              cpu_win;
  logic              dma_win;
  logic              dma_force;
  logic              rd_issue;
  owner_t            rd_owner;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  if (MEM_LAT < 1 || MEM_LAT > 4 || STARVE_LIM < 1) begin : g_param_chk
    $error("mem_port_arbiter: MEM_LAT must be 1..4 and STARVE_LIM at least 1");
  end

`ifdef MEM_ARB_STARVE_EN
  localparam int unsigned WAIT_W = $clog2(STARVE_LIM + 1);
  logic [WAIT_W-1:0] wait_q;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      wait_q <= '0;
    end else if (!bus.dma_req || dma_win) begin
      wait_q <= '0;
    end else if (wait_q != WAIT_W'(STARVE_LIM)) begin
      wait_q <= wait_q + 1'b1;
    end
  end

  assign dma_force = bus.dma_req && (wait_q == WAIT_W'(STARVE_LIM));
`else
  assign dma_force = 1'b0;
`endif

  // Grants are masked during reset so every output is quiet while Reset is high
  assign grant_ok = arb_open & ~Reset;
  assign cpu_win  = grant_ok & bus.cpu_req & ~dma_force;
  assign dma_win  = grant_ok & bus.dma_req & ~cpu_win;

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (cpu_win) begin
      sel_we    = bus.cpu_we;
      sel_addr  = bus.cpu_addr;
      sel_wdata = bus.cpu_wdata;
    end else if (dma_win) begin
      sel_we    = bus.dma_we;
      sel_addr  = bus.dma_addr;
      sel_wdata = bus.dma_wdata;
    end
  end

  assign bus.cpu_gnt   = cpu_win;
  assign bus.dma_gnt   = dma_win;
  assign bus.mem_en    = cpu_win | dma_win;
  assign bus.mem_we    = sel_we;
  assign bus.mem_addr  = sel_addr;
  assign bus.mem_wdata = sel_wdata;

  assign rd_issue = (cpu_win | dma_win) & ~sel_we;
  assign rd_owner = dma_win ? OWN_DMA : OWN_CPU;

  mem_arb_rd_tracker #(
    .DATA_W  (DATA_W),
    .MEM_LAT (MEM_LAT)
  ) u_rd_tracker (
    .CLK        (CLK),
    .Reset      (Reset),
    .rd_issue   (rd_issue),
    .rd_owner   (rd_owner),
    .mem_rdata  (bus.mem_rdata),
    .arb_open   (arb_open),
    .busy       (bus.busy),
    .cpu_rvalid (bus.cpu_rvalid),
    .cpu_rdata  (bus.cpu_rdata),
    .dma_rvalid (bus.dma_rvalid),
    .dma_rdata  (bus.dma_rdata)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed plan scenarios plus random two-port traffic.
module tb_mem_port_arbiter;

  localparam int LAT   = 3;
  localparam int SLIM  = 8;

  logic CLK = 1'b0;
  logic Reset = 1'b1;
  always #5 CLK = ~CLK;

  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_port_arbiter #(
    .ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT), .STARVE_LIM(SLIM)
  ) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          due;
    bit          own_dma;
    logic [15:0] data;
  } exp_t;
  exp_t exp_q[$];

  // reference model state: cycle of the last granted read, grants seen this cycle
  int rd_cyc = -100;
  int wcnt   = 0;
  bit g_cpu  = 0;
  bit g_dma  = 0;

  function automatic logic [15:0] mem_val(input logic [15:0] a);
    if (a == 16'h0010) return 16'hBEEF;
    return (a ^ 16'hC35A) + {a[7:0], a[15:8]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // memory macro: returns mem_val(addr) LAT cycles after a read, noise otherwise
  logic [15:0] pipe_d [LAT];
  logic        pipe_v [LAT];
  logic [15:0] noise = 16'h0;
  always @(posedge CLK) begin
    noise     <= 16'($urandom);
    pipe_v[0] <= bus.mem_en && !bus.mem_we;
    pipe_d[0] <= mem_val(bus.mem_addr);
    for (int i = 1; i < LAT; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_d[i] <= pipe_d[i-1];
    end
  end
  assign bus.mem_rdata = pipe_v[LAT-1] ? pipe_d[LAT-1] : noise;

  always @(posedge CLK) cyc <= cyc + 1;

  // grant/mux checker driven by the reference model
  bit open_m, e_cpu, e_dma, frc, e_busy;
  always @(negedge CLK) begin
    if (Reset) begin
      check("rst_cpu_gnt", bus.cpu_gnt, 0);
      check("rst_dma_gnt", bus.dma_gnt, 0);
      check("rst_mem_en", bus.mem_en, 0);
      check("rst_mem_we", bus.mem_we, 0);
      check("rst_mem_addr", bus.mem_addr, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_rvalid", {bus.cpu_rvalid, bus.dma_rvalid}, 0);
      check("rst_rdata", {bus.cpu_rdata, bus.dma_rdata}, 0);
      exp_q.delete();
      rd_cyc = -100;
      wcnt   = 0;
      g_cpu  = 0;
      g_dma  = 0;
    end else begin
      open_m = (cyc >= rd_cyc + LAT);
      e_busy = (cyc > rd_cyc) && (cyc <= rd_cyc + LAT);
`ifdef MEM_ARB_STARVE_EN
      frc = bus.dma_req && (wcnt >= SLIM);
`else
      frc = 1'b0;
`endif
      e_cpu = open_m && bus.cpu_req && !frc;
      e_dma = open_m && bus.dma_req && !e_cpu;
      check("cpu_gnt", bus.cpu_gnt, e_cpu);
      check("dma_gnt", bus.dma_gnt, e_dma);
      check("mem_en", bus.mem_en, e_cpu || e_dma);
      check("busy", bus.busy, e_busy);
      if (e_cpu || e_dma) begin
        check("mem_we", bus.mem_we, e_cpu ? bus.cpu_we : bus.dma_we);
        check("mem_addr", bus.mem_addr, e_cpu ? bus.cpu_addr : bus.dma_addr);
        check("mem_wdata", bus.mem_wdata, e_cpu ? bus.cpu_wdata : bus.dma_wdata);
        if (!(e_cpu ? bus.cpu_we : bus.dma_we)) begin
          exp_q.push_back('{due: cyc + LAT, own_dma: e_dma,
                            data: mem_val(e_cpu ? bus.cpu_addr : bus.dma_addr)});
          rd_cyc = cyc;
        end
      end
      if (!bus.dma_req || e_dma) wcnt = 0;
      else if (wcnt < SLIM) wcnt++;
      g_cpu = e_cpu;
      g_dma = e_dma;
    end
  end

  // read-return monitor: pops the scoreboard whenever a return is due or seen
  always @(negedge CLK) begin
    if (!Reset) begin
      if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        check("cpu_rvalid", bus.cpu_rvalid, !exp_q[0].own_dma);
        check("dma_rvalid", bus.dma_rvalid, exp_q[0].own_dma);
        check("cpu_rdata", bus.cpu_rdata, exp_q[0].own_dma ? 16'h0 : exp_q[0].data);
        check("dma_rdata", bus.dma_rdata, exp_q[0].own_dma ? exp_q[0].data : 16'h0);
        void'(exp_q.pop_front());
      end else begin
        check("idle_rvalid", {bus.cpu_rvalid, bus.dma_rvalid}, 0);
        check("idle_rdata", {bus.cpu_rdata, bus.dma_rdata}, 0);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_cpu(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    bus.cpu_req = r; bus.cpu_we = w; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  task automatic set_dma(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    bus.dma_req = r; bus.dma_we = w; bus.dma_addr = a; bus.dma_wdata = d;
  endtask

  task automatic idle(input int n);
    set_cpu(0, 0, 0, 0);
    set_dma(0, 0, 0, 0);
    repeat (n) step();
  endtask

  initial begin
    set_cpu(0, 0, 0, 0);
    set_dma(0, 0, 0, 0);
    repeat (3) step();
    Reset = 1'b0;
    repeat (3) step();

    // CPU read of 0x0010, memory answers 0xBEEF
    set_cpu(1, 0, 16'h0010, 16'h0);
    step();
    idle(LAT + 2);

    // simultaneous CPU write and DMA read: CPU first, DMA next cycle
    set_cpu(1, 1, 16'h0020, 16'h1234);
    set_dma(1, 0, 16'h0030, 16'h0);
    step();
    set_cpu(0, 0, 0, 0);
    step();
    idle(LAT + 2);

    // DMA read then CPU request: CPU granted on the DMA return cycle
    set_dma(1, 0, 16'h0044, 16'h0);
    step();
    set_dma(0, 0, 0, 0);
    set_cpu(1, 0, 16'h0055, 16'h0);
    repeat (LAT) step();
    idle(LAT + 2);

    // reset one cycle into a read: read is discarded, no rvalid afterwards
    set_dma(1, 0, 16'h0066, 16'h0);
    step();
    set_dma(0, 0, 0, 0);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    repeat (LAT + 3) step();

    // back-to-back CPU writes 0x0000..0x0003
    for (int i = 0; i < 4; i++) begin
      set_cpu(1, 1, 16'(i), 16'($urandom));
      step();
    end
    idle(2);

    // CPU streams reads while DMA waits; strict priority keeps DMA out
    set_cpu(1, 0, 16'($urandom), 16'h0);
    set_dma(1, 0, 16'h0077, 16'h0);
    for (int i = 0; i < 40; i++) begin
      step();
      if (g_cpu) set_cpu(1, 0, 16'($urandom), 16'h0);
      if (g_dma) set_dma(0, 0, 0, 0);
    end
    idle(LAT + 2);

    // random traffic on both ports
    for (int i = 0; i < 500; i++) begin
      if (bus.cpu_req && (g_cpu || $urandom_range(0, 19) == 0)) bus.cpu_req = 0;
      if (!bus.cpu_req && $urandom_range(0, 2) != 0)
        set_cpu(1, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
      if (bus.dma_req && (g_dma || $urandom_range(0, 19) == 0)) bus.dma_req = 0;
      if (!bus.dma_req && $urandom_range(0, 2) != 0)
        set_dma(1, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
      step();
    end
    idle(LAT + 3);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
